// File: rtl/coeff_zigzag_buffer_if.sv
// Bus between the CAVLC run/level stage, the zig-zag buffer and the
// inverse-quant consumer. The slave side is the buffer itself.
interface coeff_zigzag_buffer_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] coeff_in;
  logic [1:0]   blk_mode;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_level;
  logic [3:0]   out_idx;
  logic         out_last;
  logic [4:0]   out_nz_count;

  modport slave (
    input  in_valid, coeff_in, blk_mode, out_ready,
    output in_ready, out_valid, out_level, out_idx, out_last, out_nz_count
  );

  modport master (
    output in_valid, coeff_in, blk_mode, out_ready,
    input  in_ready, out_valid, out_level, out_idx, out_last, out_nz_count
  );
endinterface

// File: rtl/coeff_zigzag_buffer.sv
// Captures one block of 16 scan-order levels, then streams them in raster
// order (inverse zig-zag) over a valid/ready handshake. One block in flight.
module coeff_zigzag_buffer (
  input  logic                  clk,
  input  logic                  reset_n,  // active-high synchronous reset
  coeff_zigzag_buffer_if.slave  bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0][15:0]  r_buf;
  logic [1:0]         r_mode;
  logic [3:0]         r_idx;
  logic [4:0]         r_nz;

  logic        w_in_ready, w_out_valid;
  logic        w_capture, w_hs, w_last;
  logic [1:0]  w_mode_in;
  logic [3:0]  w_last_idx, w_scan;
  logic [4:0]  w_nz_lim, w_nz_in;
  logic [15:0] w_level;

  // Mode 3 is an alias of the 16-coeff mode, so fold it away at capture.
  assign w_mode_in  = (bus.blk_mode == 2'd3) ? 2'd0 : bus.blk_mode;
  assign w_last_idx = (r_mode == 2'd2) ? 4'd3 : 4'd15;
  assign w_last     = (r_state == STREAM) && (r_idx == w_last_idx);
  assign w_capture  = w_in_ready & bus.in_valid;
  assign w_hs       = w_out_valid & bus.out_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_out_valid = 1'b1;
        if (bus.out_ready && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Nonzero count over the levels the incoming mode actually uses
  always_comb begin
    case (w_mode_in)
      2'd1:    w_nz_lim = 5'd15;
      2'd2:    w_nz_lim = 5'd4;
      default: w_nz_lim = 5'd16;
    endcase
    w_nz_in = 5'd0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(w_nz_lim) && bus.coeff_in[16*k +: 16] != 16'd0)
        w_nz_in = w_nz_in + 5'd1;
    end
  end

  // Block buffer, mode, nonzero count and raster index counter
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_buf  <= '0;
      r_mode <= 2'd0;
      r_idx  <= 4'd0;
      r_nz   <= 5'd0;
    end else if (w_capture) begin
      r_buf  <= bus.coeff_in;
      r_mode <= w_mode_in;
      r_idx  <= 4'd0;
      r_nz   <= w_nz_in;
    end else if (w_hs) begin
      r_idx  <= w_last ? 4'd0 : r_idx + 4'd1;
    end
  end

  // Raster position -> scan position of the 4x4 zig-zag
  always_comb begin
    case (r_idx)
      4'd0:    w_scan = 4'd0;
      4'd1:    w_scan = 4'd1;
      4'd2:    w_scan = 4'd5;
      4'd3:    w_scan = 4'd6;
      4'd4:    w_scan = 4'd2;
      4'd5:    w_scan = 4'd4;
      4'd6:    w_scan = 4'd7;
      4'd7:    w_scan = 4'd12;
      4'd8:    w_scan = 4'd3;
      4'd9:    w_scan = 4'd8;
      4'd10:   w_scan = 4'd11;
      4'd11:   w_scan = 4'd13;
      4'd12:   w_scan = 4'd9;
      4'd13:   w_scan = 4'd10;
      4'd14:   w_scan = 4'd14;
      default: w_scan = 4'd15;
    endcase
  end

  // Level select: AC blocks carry no DC, so scan 0 is a zero and the rest
  // shift down by one; chroma DC bypasses the zig-zag.
  always_comb begin
    w_level = 16'd0;
    if (w_out_valid) begin
      case (r_mode)
        2'd2:    w_level = r_buf[r_idx];
        2'd1:    w_level = (w_scan == 4'd0) ? 16'd0 : r_buf[w_scan - 4'd1];
        default: w_level = r_buf[w_scan];
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_level    = w_level;
  assign bus.out_idx      = r_idx;
  assign bus.out_last     = w_last;
  assign bus.out_nz_count = r_nz;

endmodule

// File: tb/tb_coeff_zigzag_buffer.sv
// Scoreboard bench for coeff_zigzag_buffer: the driver pushes the expected
// raster stream from a zig-zag walk model; the monitor pops on handshakes.
module tb_coeff_zigzag_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coeff_zigzag_buffer_if bus ();

  coeff_zigzag_buffer dut (
    .clk     (clk),
    .reset_n (rst),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [15:0] lvl;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [4:0]  exp_nz = 5'd0;
  logic [4:0]  model_nz;
  int          zz_pos [16];   // scan position -> raster position

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walk the 4x4 anti-diagonals, alternating direction, to get scan order.
  task automatic build_zz();
    int s = 0;
    for (int d = 0; d < 7; d++) begin
      for (int i = 0; i < 4; i++) begin
        int row = (d % 2 == 1) ? i : 3 - i;
        int col = d - row;
        if (col >= 0 && col < 4) begin
          zz_pos[s] = 4 * row + col;
          s++;
        end
      end
    end
  endtask

  // Reference: place scan-order coefficients into a raster array.
  task automatic model(input logic [255:0] blk, input logic [1:0] mode);
    logic [15:0] ras [16];
    int n;
    int m = (mode == 2'd3) ? 0 : int'(mode);
    model_nz = 5'd0;
    if (m == 2) begin
      n = 4;
      for (int k = 0; k < 4; k++) ras[k] = blk[16*k +: 16];
    end else begin
      n = 16;
      for (int s = 0; s < 16; s++) begin
        logic [15:0] c;
        if (m == 0)      c = blk[16*s +: 16];
        else if (s == 0) c = 16'd0;
        else             c = blk[16*(s-1) +: 16];
        ras[zz_pos[s]] = c;
      end
    end
    for (int k = 0; k < 16; k++) begin
      int used = (m == 0) ? 16 : (m == 1) ? 15 : 4;
      if (k < used && blk[16*k +: 16] != 16'd0) model_nz = model_nz + 5'd1;
    end
    for (int r = 0; r < n; r++) sb.push_back({ras[r], 4'(r), r == n - 1});
  endtask

  // Monitor: pop on every handshake, check stability across stalls.
  logic        prev_stall = 1'b0;
  logic [15:0] h_lvl;
  logic [3:0]  h_idx;
  logic        h_last;
  exp_t        e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        cmp("stall_level", bus.out_level, h_lvl);
        cmp("stall_idx",   bus.out_idx,   h_idx);
        cmp("stall_last",  bus.out_last,  h_last);
      end
      if (bus.out_valid) begin
        cmp("nz_count", bus.out_nz_count, exp_nz);
        if (bus.out_ready) begin
          prev_stall = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL extra_output: idx %0h level %0h with nothing expected", bus.out_idx, bus.out_level);
          end else begin
            e = sb.pop_front();
            cmp("level", bus.out_level, e.lvl);
            cmp("idx",   bus.out_idx,   e.idx);
            cmp("last",  bus.out_last,  e.last);
          end
        end else begin
          prev_stall = 1'b1;
          h_lvl  = bus.out_level;
          h_idx  = bus.out_idx;
          h_last = bus.out_last;
        end
      end else begin
        prev_stall = 1'b0;
        cmp("idle_last", bus.out_last, 1'b0);
      end
    end
  end

  // rdy_pat: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  task automatic send(input logic [255:0] blk, input logic [1:0] mode,
                      input int rdy_pat, input bit stray);
    int cyc = 0;
    cmp("in_ready_idle", bus.in_ready, 1'b1);
    model(blk, mode);
    bus.coeff_in = blk;
    bus.blk_mode = mode;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coeff_in = {8{$urandom}};
    bus.blk_mode = 2'($urandom_range(0, 3));
    exp_nz = model_nz;
    cmp("first_valid", bus.out_valid, 1'b1);
    cmp("first_idx", bus.out_idx, 4'd0);
    while (sb.size() != 0 && cyc < 200) begin
      case (rdy_pat)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stray && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b1;
        bus.coeff_in = {8{$urandom}};
        bus.blk_mode = 2'($urandom_range(0, 3));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (cyc >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL stream_timeout: %0d outputs still pending after %0d cycles", sb.size(), cyc);
      sb.delete();
    end
    cmp("in_ready_after_last", bus.in_ready, 1'b1);
    cmp("valid_after_last", bus.out_valid, 1'b0);
    cmp("nz_hold", bus.out_nz_count, exp_nz);
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] rand_blk();
    logic [255:0] b;
    for (int k = 0; k < 16; k++) begin
      int sel = $urandom_range(0, 7);
      if (sel < 3)       b[16*k +: 16] = 16'd0;
      else if (sel == 3) b[16*k +: 16] = 16'h8000;
      else if (sel == 4) b[16*k +: 16] = 16'h7FFF;
      else               b[16*k +: 16] = 16'($urandom);
    end
    return b;
  endfunction

  logic [255:0] seq, blk;
  initial begin
    build_zz();
    bus.in_valid  = 1'b0;
    bus.coeff_in  = '0;
    bus.blk_mode  = 2'd0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) seq[16*k +: 16] = 16'(k + 1);

    // Reset, with in_valid asserted to show it is not captured
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.coeff_in = seq;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cmp("rst_in_ready",  bus.in_ready,     1'b1);
    cmp("rst_out_valid", bus.out_valid,    1'b0);
    cmp("rst_out_last",  bus.out_last,     1'b0);
    cmp("rst_out_idx",   bus.out_idx,      4'd0);
    cmp("rst_out_level", bus.out_level,    16'd0);
    cmp("rst_nz",        bus.out_nz_count, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("rst_no_capture", bus.out_valid, 1'b0);

    // Directed blocks
    send(seq, 2'd0, 0, 1'b0);                          // mode 0 ramp
    blk = seq; blk[255:240] = 16'h7FFF;
    send(blk, 2'd1, 0, 1'b0);                          // mode 1 ramp
    blk = {192'h0, 16'h0000, 16'h0002, 16'h0000, 16'hFFFD};
    blk[255:64] = {6{$urandom | 32'h1}};
    send(blk, 2'd2, 0, 1'b0);                          // chroma DC with garbage
    send(seq, 2'd0, 1, 1'b1);                          // stalls + stray in_valid
    send(256'h0, 2'd0, 2, 1'b0);                       // all zero
    send(rand_blk(), 2'd3, 1, 1'b1);                   // mode 3 alias

    // Reset after the 5th handshake of a mode 0 block
    begin
      int cyc = 0;
      model(seq, 2'd0);
      bus.coeff_in = seq; bus.blk_mode = 2'd0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      exp_nz = model_nz;
      bus.out_ready = 1'b1;
      while (sb.size() > 11 && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      cmp("pre_reset_handshakes", 32'(sb.size()), 32'd11);
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.coeff_in = rand_blk();
      @(posedge clk); #1;
      sb.delete();
      exp_nz = 5'd0;
      cmp("midrst_out_valid", bus.out_valid,    1'b0);
      cmp("midrst_nz",        bus.out_nz_count, 5'd0);
      cmp("midrst_idx",       bus.out_idx,      4'd0);
      cmp("midrst_level",     bus.out_level,    16'd0);
      cmp("midrst_in_ready",  bus.in_ready,     1'b1);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      cmp("midrst_no_resume", bus.out_valid, 1'b0);
      send(rand_blk(), 2'd0, 0, 1'b0);
    end

    // Randomized blocks
    for (int b = 0; b < 24; b++)
      send(rand_blk(), 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
